// File: rtl/rs_544_522_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rs_544_522_encoder
// Purpose  : Systematic RS(544,522) encoder over GF(2^10), 32 symbols per beat,
//            17 beats per codeword with 22 parity symbols in the last beat.
// Revision : 1.0
// ============================================================================
module rs_544_522_encoder #(
   parameter int         W         = 10,
   parameter int         M         = 32,
   parameter int         T         = 11,
   parameter int         K         = 522,
   parameter int         NC        = 544,
   parameter logic [9:0] PRIM_POLY = 10'h009,
   parameter int         FCR       = 0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           in_valid_i,
   output logic           in_ready_o,
   input  logic           in_start_i,
   input  logic           in_last_i,
   input  logic [M*W-1:0] data_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic           out_start_o,
   output logic           out_last_o,
   output logic [M*W-1:0] data_o,
   output logic           err_o
);

   localparam int NP    = 2 * T;
   localparam int BEATS = NC / M;
   localparam int TAIL  = K - (BEATS - 1) * M;
   localparam int CW    = $clog2(BEATS);
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

   typedef logic [NP-1:0][W-1:0] rem_t;
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   function automatic logic [W-1:0] gf_xtime(input logic [W-1:0] a);
      return {a[W-2:0], 1'b0} ^ (a[W-1] ? PRIM_POLY : '0);
   endfunction

   function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] acc;
      logic [W-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < W; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gf_xtime(sh);
      end
      return acc;
   endfunction

   // g(x) = prod (x + a^i), i = FCR .. FCR+NP-1; leading coefficient 1 is implicit.
   function automatic rem_t gen_poly();
      logic [NP:0][W-1:0] g;
      logic [W-1:0]       root;
      g    = '0;
      g[0] = W'(1);
      root = W'(1);
      for (int i = 0; i < FCR; i++) root = gf_xtime(root);
      for (int i = 0; i < NP; i++) begin
         for (int j = NP; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
         g[0] = gf_mul(g[0], root);
         root = gf_xtime(root);
      end
      return g[NP-1:0];
   endfunction

   localparam rem_t GEN = gen_poly();

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   rem_t            r_q, r_d;
   logic            out_valid_q, out_valid_d;
   logic            out_start_q, out_start_d;
   logic            out_last_q, out_last_d;
   logic [M*W-1:0]  data_q, data_d;
   logic            err_q, err_d;

   logic            accept;
   logic            start_accept;
   rem_t            r_in;
   rem_t            r_full;
   rem_t            r_tail;
   logic [W-1:0]    fb;

   assign in_ready_o   = ~out_valid_q | out_ready_i;
   assign accept       = in_valid_i & in_ready_o;
   assign start_accept = accept & in_start_i;

   // Unrolled LFSR, lane 31 first; r_tail taps the chain after the last message lane of beat 16.
   always_comb begin
      r_in   = start_accept ? '0 : r_q;
      r_full = r_in;
      r_tail = '0;
      fb     = '0;
      for (int k = 0; k < M; k++) begin
         fb = data_i[(M-1-k)*W +: W] ^ r_full[NP-1];
         for (int j = NP - 1; j > 0; j--) r_full[j] = r_full[j-1] ^ gf_mul(fb, GEN[j]);
         r_full[0] = gf_mul(fb, GEN[0]);
         if (k == TAIL - 1) r_tail = r_full;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      out_valid_d = out_valid_q & ~out_ready_i;
      out_start_d = out_start_q;
      out_last_d  = out_last_q;
      data_d      = data_q;
      err_d       = 1'b0;
      if (accept) begin
         if (in_start_i) begin
            // A start while running aborts the current frame and restarts at beat 0.
            err_d       = (state_q == S_RUN) | in_last_i;
            state_d     = S_RUN;
            cnt_d       = CW'(1);
            r_d         = r_full;
            out_valid_d = 1'b1;
            out_start_d = 1'b1;
            out_last_d  = 1'b0;
            data_d      = data_i;
         end else if (state_q == S_IDLE) begin
            err_d = 1'b1;
         end else if (cnt_q == LAST_CNT) begin
            err_d       = ~in_last_i;
            state_d     = S_IDLE;
            cnt_d       = '0;
            r_d         = '0;
            out_valid_d = 1'b1;
            out_start_d = 1'b0;
            out_last_d  = 1'b1;
            data_d      = {data_i[M*W-1:NP*W], r_tail};
         end else begin
            err_d       = in_last_i;
            cnt_d       = cnt_q + 1'b1;
            r_d         = r_full;
            out_valid_d = 1'b1;
            out_start_d = 1'b0;
            out_last_d  = 1'b0;
            data_d      = data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         r_q         <= '0;
         out_valid_q <= 1'b0;
         out_start_q <= 1'b0;
         out_last_q  <= 1'b0;
         data_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         out_valid_q <= out_valid_d;
         out_start_q <= out_start_d;
         out_last_q  <= out_last_d;
         data_q      <= data_d;
         err_q       <= err_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_start_o = out_start_q;
   assign out_last_o  = out_last_q;
   assign data_o      = data_q;
   assign err_o       = err_q;

endmodule
`default_nettype wire
